// File: rtl/coding_pkg.sv
// Shared definitions for the Golomb-Rice coding path: FSM state encoding and
// the parameter legality check used at elaboration.
package coding_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    // A word must hold a full escape tail plus its terminating bit, and the length field must reach CODE_WIDTH.
    function automatic bit params_ok(input int unsigned data_width,
                                     input int unsigned code_width,
                                     input int unsigned bit_amt_width);
        longint unsigned span;
        span = longint'(1) << bit_amt_width;
        return (code_width >= data_width + 1) && (span > longint'(code_width));
    endfunction

endpackage

// File: rtl/coding_golomb_split.sv
// Combinational Golomb-Rice split: maps (value, k) to a run of leading zeros
// and a right-aligned tail, switching to the escape form for large quotients.
module coding_golomb_split #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned K_WIDTH    = 5,
    parameter int unsigned LIMIT      = 32
) (
    input  logic [DATA_WIDTH-1:0]                  value,
    input  logic [K_WIDTH-1:0]                     k,
    output logic [$clog2(LIMIT+1)-1:0]             zeros,
    output logic [DATA_WIDTH:0]                    tail,
    output logic [$clog2(DATA_WIDTH+2)-1:0]        tail_len
);

    localparam int unsigned TAIL_W = DATA_WIDTH + 1;
    localparam int unsigned TLEN_W = $clog2(DATA_WIDTH + 2);
    localparam int unsigned ZERO_W = $clog2(LIMIT + 1);

    logic [TLEN_W-1:0]     k_sat;
    logic [DATA_WIDTH-1:0] quot;
    logic [TAIL_W-1:0]     unit;
    logic [TAIL_W-1:0]     rmd;

    always_comb begin
        k_sat    = (32'(k) > DATA_WIDTH) ? TLEN_W'(DATA_WIDTH) : TLEN_W'(k);
        quot     = value >> k_sat;
        unit     = TAIL_W'(1) << k_sat;
        rmd      = TAIL_W'(value) & (unit - TAIL_W'(1));
        zeros    = '0;
        tail     = '0;
        tail_len = '0;
        if (32'(quot) >= 32'(LIMIT)) begin
            // Escape: fixed-length zero run, then the raw value.
            zeros    = ZERO_W'(LIMIT);
            tail     = TAIL_W'(value);
            tail_len = TLEN_W'(DATA_WIDTH);
        end else begin
            zeros    = ZERO_W'(quot);
            tail     = unit | rmd;
            tail_len = k_sat + TLEN_W'(1);
        end
    end

endmodule

// File: rtl/coding_golomb_coder.sv
// Golomb-Rice coder: emits right-aligned (code, length) words, splitting long
// zero prefixes over several words and stalling the input while it does so.
module coding_golomb_coder #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned K_WIDTH       = 5,
    parameter int unsigned CODE_WIDTH    = 39,
    parameter int unsigned BIT_AMT_WIDTH = 6,
    parameter int unsigned LIMIT         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    input_value,
    input  logic [K_WIDTH-1:0]       input_k,
    input  logic                     input_last,
    input  logic                     input_valid,
    output logic                     input_ready,
    output logic [CODE_WIDTH-1:0]    output_code_data,
    output logic [BIT_AMT_WIDTH-1:0] output_length_data,
    output logic                     output_last,
    output logic                     output_valid,
    input  logic                     output_ready
);

    import coding_pkg::*;

    localparam int unsigned TAIL_W = DATA_WIDTH + 1;
    localparam int unsigned TLEN_W = $clog2(DATA_WIDTH + 2);
    localparam int unsigned ZERO_W = $clog2(LIMIT + 1);

    if (!params_ok(DATA_WIDTH, CODE_WIDTH, BIT_AMT_WIDTH)) begin : g_param_err
        $error("coding_golomb_coder: illegal DATA_WIDTH/CODE_WIDTH/BIT_AMT_WIDTH combination");
    end

    logic [ZERO_W-1:0] zeros;
    logic [TAIL_W-1:0] tail;
    logic [TLEN_W-1:0] tail_len;

    coding_golomb_split #(
        .DATA_WIDTH (DATA_WIDTH),
        .K_WIDTH    (K_WIDTH),
        .LIMIT      (LIMIT)
    ) u_split (
        .value    (input_value),
        .k        (input_k),
        .zeros    (zeros),
        .tail     (tail),
        .tail_len (tail_len)
    );

    state_t            state;
    logic [ZERO_W-1:0] rem;
    logic [TAIL_W-1:0] tail_q;
    logic [TLEN_W-1:0] tail_len_q;
    logic              last_q;

    logic        slot_free;
    logic        accept;
    logic [31:0] in_total;
    logic [31:0] in_chunk;
    logic        in_fits;
    logic [31:0] sp_total;
    logic [31:0] sp_chunk;
    logic        sp_fits;

    assign slot_free   = !output_valid || output_ready;
    assign input_ready = (state == IDLE) && slot_free && !rst;
    assign accept      = input_valid && input_ready;

    // Word sizing for a fresh sample and for the pending remainder.
    always_comb begin
        in_total = 32'(zeros) + 32'(tail_len);
        in_fits  = in_total <= CODE_WIDTH;
        in_chunk = (32'(zeros) < CODE_WIDTH) ? 32'(zeros) : CODE_WIDTH;
        sp_total = 32'(rem) + 32'(tail_len_q);
        sp_fits  = sp_total <= CODE_WIDTH;
        sp_chunk = (32'(rem) < CODE_WIDTH) ? 32'(rem) : CODE_WIDTH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            output_valid       <= 1'b0;
            output_code_data   <= '0;
            output_length_data <= '0;
            output_last        <= 1'b0;
            rem                <= '0;
            tail_q             <= '0;
            tail_len_q         <= '0;
            last_q             <= 1'b0;
        end else begin
            if (output_valid && output_ready) begin
                output_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        output_valid <= 1'b1;
                        if (in_fits) begin
                            output_code_data   <= CODE_WIDTH'(tail);
                            output_length_data <= BIT_AMT_WIDTH'(in_total);
                            output_last        <= input_last;
                        end else begin
                            output_code_data   <= '0;
                            output_length_data <= BIT_AMT_WIDTH'(in_chunk);
                            output_last        <= 1'b0;
                            rem                <= ZERO_W'(32'(zeros) - in_chunk);
                            tail_q             <= tail;
                            tail_len_q         <= tail_len;
                            last_q             <= input_last;
                            state              <= SPLIT;
                        end
                    end
                end
                SPLIT: begin
                    if (slot_free) begin
                        output_valid <= 1'b1;
                        if (sp_fits) begin
                            output_code_data   <= CODE_WIDTH'(tail_q);
                            output_length_data <= BIT_AMT_WIDTH'(sp_total);
                            output_last        <= last_q;
                            state              <= IDLE;
                        end else begin
                            output_code_data   <= '0;
                            output_length_data <= BIT_AMT_WIDTH'(sp_chunk);
                            output_last        <= 1'b0;
                            rem                <= ZERO_W'(32'(rem) - sp_chunk);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coding_golomb_coder.sv
// Self-checking bench for coding_golomb_coder: directed cases with literal
// expectations, then randomized samples against an arithmetic reference model.
module tb_coding_golomb_coder;

    localparam int unsigned DW  = 16;
    localparam int unsigned KW  = 5;
    localparam int unsigned CW  = 39;
    localparam int unsigned BW  = 6;
    localparam int unsigned LIM = 32;

    typedef struct {
        longint unsigned code;
        int unsigned     len;
        bit              last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] input_value;
    logic [KW-1:0] input_k;
    logic          input_last;
    logic          input_valid;
    logic          input_ready;
    logic [CW-1:0] output_code_data;
    logic [BW-1:0] output_length_data;
    logic          output_last;
    logic          output_valid;
    logic          output_ready;

    coding_golomb_coder dut (
        .clk                (clk),
        .rst                (rst),
        .input_value        (input_value),
        .input_k            (input_k),
        .input_last         (input_last),
        .input_valid        (input_valid),
        .input_ready        (input_ready),
        .output_code_data   (output_code_data),
        .output_length_data (output_length_data),
        .output_last        (output_last),
        .output_valid       (output_valid),
        .output_ready       (output_ready)
    );

    always #5 clk = ~clk;

    word_t exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    bit    accepted;
    bit    rand_ready = 1'b0;

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input longint unsigned code, input int unsigned len, input bit last);
        word_t w;
        w.code = code;
        w.len  = len;
        w.last = last;
        exp_q.push_back(w);
    endtask

    // Reference: Golomb-Rice code as a zero count plus tail, chopped into words of at most CW bits.
    task automatic model(input int unsigned v, input int unsigned k, input bit last);
        int unsigned     kk, q, zeros, tl, n;
        longint unsigned tail;
        kk = (k > DW) ? DW : k;
        q  = v / (1 << kk);
        if (q < LIM) begin
            zeros = q;
            tail  = longint'(1 << kk) + longint'(v % (1 << kk));
            tl    = kk + 1;
        end else begin
            zeros = LIM;
            tail  = longint'(v);
            tl    = DW;
        end
        while (zeros + tl > CW) begin
            n = (zeros < CW) ? zeros : CW;
            push(0, n, 1'b0);
            zeros = zeros - n;
        end
        push(tail, zeros + tl, last);
    endtask

    // One clock: settle inputs, score any output transfer, then advance past the edge.
    task automatic cycle();
        word_t w;
        if (rand_ready) output_ready = ($urandom_range(0, 3) != 0);
        #1;
        accepted = input_valid && input_ready;
        if (output_valid && output_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 0, 1);
            end else begin
                w = exp_q.pop_front();
                check("code", longint'(output_code_data), w.code);
                check("length", longint'(output_length_data), longint'(w.len));
                check("last", longint'(output_last), longint'(w.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int unsigned v, input int unsigned k, input bit last,
                        input bit use_model, input bit no_stall);
        input_value = DW'(v);
        input_k     = KW'(k);
        input_last  = last;
        input_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (i == 0 && no_stall) check("no_bubble", longint'(accepted), 1);
            if (accepted) begin
                if (use_model) model(v, (k > DW) ? DW : k, last);
                input_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", 0, 1);
        input_valid = 1'b0;
    endtask

    task automatic drain();
        input_valid  = 1'b0;
        output_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !output_valid) break;
            cycle();
        end
        check("drain_pending", longint'(exp_q.size()), 0);
        check("drain_idle", longint'(output_valid), 0);
    endtask

    initial begin
        longint unsigned snap_code;
        int unsigned     snap_len;
        int unsigned     rv, rk;

        rst          = 1'b1;
        input_value  = '0;
        input_k      = '0;
        input_last   = 1'b0;
        input_valid  = 1'b0;
        output_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_input_ready", longint'(input_ready), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid", longint'(output_valid), 0);
        check("rst_code", longint'(output_code_data), 0);
        check("rst_length", longint'(output_length_data), 0);
        check("rst_last", longint'(output_last), 0);
        check("idle_ready", longint'(input_ready), 1);

        // Single-word codes back to back.
        push(6, 5, 1'b0);
        push(1, 1, 1'b0);
        push(13, 35, 1'b0);
        send(10, 2, 1'b0, 1'b0, 1'b0);
        send(0, 0, 1'b0, 1'b0, 1'b1);
        send(253, 3, 1'b0, 1'b0, 1'b1);
        #1;
        check("q31_ready", longint'(input_ready), 1);
        drain();

        // Two-word split, input stalled in between.
        push(0, 30, 1'b0);
        push(1031, 11, 1'b0);
        send(30727, 10, 1'b0, 1'b0, 1'b0);
        check("split_stall", longint'(input_ready), 0);
        drain();

        // Escape and k saturation.
        push(0, 32, 1'b0);
        push(200, 16, 1'b0);
        push(65541, 17, 1'b0);
        send(200, 0, 1'b0, 1'b0, 1'b0);
        send(5, 20, 1'b0, 1'b0, 1'b0);
        drain();

        // Backpressure on the first split word.
        push(0, 30, 1'b0);
        push(1031, 11, 1'b0);
        output_ready = 1'b0;
        send(30727, 10, 1'b0, 1'b0, 1'b0);
        snap_code = longint'(output_code_data);
        snap_len  = int'(output_length_data);
        check("hold_first_valid", longint'(output_valid), 1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("hold_valid", longint'(output_valid), 1);
            check("hold_code", longint'(output_code_data), snap_code);
            check("hold_length", longint'(output_length_data), longint'(snap_len));
            check("hold_ready", longint'(input_ready), 0);
        end
        drain();

        // Escape flagged last: only the final word carries last.
        push(0, 32, 1'b0);
        push(200, 16, 1'b1);
        send(200, 0, 1'b1, 1'b0, 1'b0);
        drain();

        // Reset while a split is pending.
        push(0, 30, 1'b0);
        send(30727, 10, 1'b0, 1'b0, 1'b0);
        output_ready = 1'b0;
        rst          = 1'b1;
        #1;
        check("rst_split_ready", longint'(input_ready), 0);
        @(posedge clk);
        #1;
        check("rst_split_valid", longint'(output_valid), 0);
        rst = 1'b0;
        exp_q.delete();
        output_ready = 1'b1;
        push(6, 5, 1'b0);
        send(10, 2, 1'b0, 1'b0, 1'b1);
        drain();

        // Randomized samples with random backpressure against the model.
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            rk = $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) begin
                rv = $urandom_range(0, (64 << ((rk > DW) ? DW : rk)) - 1);
                if (rv > 65535) rv = 65535;
            end else begin
                rv = $urandom_range(0, 65535);
            end
            send(rv, rk, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        rand_ready = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
